// File: rtl/sram_access_sequencer_if.sv
// Command/status and SRAM pin bundle for the SRAM access sequencer.
// The slave side is the sequencer; the master side is the controller plus SRAM model.
interface sram_access_sequencer_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              cmd_rw;
   logic              cmd_go;
   logic              busy;
   logic              done;
   logic              overrun;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;
   logic [DATA_W-1:0] sram_dq_out;
   logic              sram_dq_oe;
   logic [DATA_W-1:0] sram_dq_in;

   modport master (
      output cmd_addr, cmd_wdata, cmd_rw, cmd_go, sram_dq_in,
      input  busy, done, overrun, rdata,
      input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_out, sram_dq_oe
   );

   modport slave (
      input  cmd_addr, cmd_wdata, cmd_rw, cmd_go, sram_dq_in,
      output busy, done, overrun, rdata,
      output sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_out, sram_dq_oe
   );
endinterface

// File: rtl/sram_access_sequencer.sv
// Single-access asynchronous SRAM sequencer: SETUP, WAIT_CYCLES strobe cycles, HOLD.
// Every SRAM-facing output is a flop so the pad timing is clean.
module sram_access_sequencer #(
   parameter int ADDR_W      = 11,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input logic clk,
   input logic reset,
   sram_access_sequencer_if.slave bus
);

   localparam int EFF_WAIT = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
   localparam int CNT_W    = (EFF_WAIT > 1) ? $clog2(EFF_WAIT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      HOLD
   } state_t;

   state_t            state;
   logic              go_q;
   logic              go_rise;
   logic [CNT_W-1:0]  cnt;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              rw_q;

   logic              busy_r;
   logic              done_r;
   logic              overrun_r;
   logic [DATA_W-1:0] rdata_r;
   logic [ADDR_W-1:0] addr_r;
   logic              ce_n_r;
   logic              oe_n_r;
   logic              we_n_r;
   logic [DATA_W-1:0] dq_out_r;
   logic              dq_oe_r;

   assign go_rise = bus.cmd_go & ~go_q;

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.overrun     = overrun_r;
   assign bus.rdata       = rdata_r;
   assign bus.sram_addr   = addr_r;
   assign bus.sram_ce_n   = ce_n_r;
   assign bus.sram_oe_n   = oe_n_r;
   assign bus.sram_we_n   = we_n_r;
   assign bus.sram_dq_out = dq_out_r;
   assign bus.sram_dq_oe  = dq_oe_r;

   // Outputs are loaded on the edge that enters each state, so they are valid
   // for the whole cycle spent in that state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         go_q      <= 1'b0;
         cnt       <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rw_q      <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         overrun_r <= 1'b0;
         rdata_r   <= '0;
         addr_r    <= '0;
         ce_n_r    <= 1'b1;
         oe_n_r    <= 1'b1;
         we_n_r    <= 1'b1;
         dq_out_r  <= '0;
         dq_oe_r   <= 1'b0;
      end else begin
         go_q <= bus.cmd_go;

         // A request outside IDLE (including the HOLD->IDLE edge) is never executed.
         if (go_rise && (state != IDLE)) begin
            overrun_r <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (go_rise) begin
                  addr_q    <= bus.cmd_addr;
                  wdata_q   <= bus.cmd_wdata;
                  rw_q      <= bus.cmd_rw;
                  done_r    <= 1'b0;
                  overrun_r <= 1'b0;
                  busy_r    <= 1'b1;
                  addr_r    <= bus.cmd_addr;
                  dq_out_r  <= bus.cmd_wdata;
                  dq_oe_r   <= bus.cmd_rw;
                  ce_n_r    <= 1'b0;
                  oe_n_r    <= 1'b1;
                  we_n_r    <= 1'b1;
                  state     <= SETUP;
               end else begin
                  busy_r  <= 1'b0;
                  ce_n_r  <= 1'b1;
                  oe_n_r  <= 1'b1;
                  we_n_r  <= 1'b1;
                  dq_oe_r <= 1'b0;
               end
            end

            SETUP: begin
               cnt      <= CNT_W'(EFF_WAIT);
               addr_r   <= addr_q;
               dq_out_r <= wdata_q;
               dq_oe_r  <= rw_q;
               ce_n_r   <= 1'b0;
               oe_n_r   <= rw_q;
               we_n_r   <= ~rw_q;
               state    <= ACCESS;
            end

            ACCESS: begin
               if (cnt == CNT_W'(1)) begin
                  if (!rw_q) begin
                     rdata_r <= bus.sram_dq_in;
                  end
                  oe_n_r <= 1'b1;
                  we_n_r <= 1'b1;
                  state  <= HOLD;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            HOLD: begin
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               ce_n_r  <= 1'b1;
               oe_n_r  <= 1'b1;
               we_n_r  <= 1'b1;
               dq_oe_r <= 1'b0;
               state   <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench for sram_access_sequencer with a behavioural SRAM and an access scoreboard.
// A second instance exercises WAIT_CYCLES=0.
module tb_sram_access_sequencer;

   typedef struct packed {
      logic        rw;
      logic [10:0] addr;
      logic [7:0]  rdata_exp;
   } sb_item_t;

   logic clk = 1'b0;
   logic reset;

   int test_count = 0;
   int fail_count = 0;
   int access_seen = 0;
   int expected_accesses = 0;

   sb_item_t   sb[$];
   logic [7:0] mem     [0:2047];
   logic [7:0] ref_mem [0:2047];
   logic [7:0] model_rdata;

   sram_access_sequencer_if #(.ADDR_W(11), .DATA_W(8)) bus ();
   sram_access_sequencer_if #(.ADDR_W(11), .DATA_W(8)) bus0 ();

   sram_access_sequencer #(.ADDR_W(11), .DATA_W(8), .WAIT_CYCLES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   sram_access_sequencer #(.ADDR_W(11), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   always #5 clk = ~clk;

   // SRAM model drives read data only while selected and output-enabled.
   assign bus.sram_dq_in  = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr] : 8'h00;
   assign bus0.sram_dq_in = 8'h6B;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pushExpected(input logic [10:0] addr, input logic [7:0] wdata, input logic rw);
      sb_item_t it;
      if (rw) ref_mem[addr] = wdata;
      else    model_rdata = ref_mem[addr];
      it.rw = rw;
      it.addr = addr;
      it.rdata_exp = model_rdata;
      sb.push_back(it);
      expected_accesses++;
   endtask

   // Drives a command with a go rising edge; returns in the SETUP cycle.
   task automatic applyStimulus(input logic [10:0] addr, input logic [7:0] wdata, input logic rw);
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.cmd_rw    = rw;
      bus.cmd_go    = 1'b1;
      pushExpected(addr, wdata, rw);
      tick(1);
   endtask

   task automatic waitDone(input string tag);
      int k = 0;
      while (!bus.done && k < 20) begin
         tick(1);
         k++;
      end
      checkOutput(tag, {31'd0, bus.done}, 32'd1);
   endtask

   // Per-cycle pin check from SETUP through the first IDLE cycle (WAIT_CYCLES=2).
   task automatic runCycles(input logic rw, input logic [10:0] addr, input logic [7:0] wdata);
      logic [4:0] exp_ce   = 5'b10000;
      logic [4:0] exp_busy = 5'b01111;
      logic [4:0] exp_done = 5'b10000;
      logic [4:0] exp_we   = rw ? 5'b11001 : 5'b11111;
      logic [4:0] exp_oen  = rw ? 5'b11111 : 5'b11001;
      logic [4:0] exp_dqoe = rw ? 5'b01111 : 5'b00000;
      string p = rw ? "wr" : "rd";
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick(1);
         checkOutput($sformatf("%s_ce_n_c%0d", p, i), {31'd0, bus.sram_ce_n}, {31'd0, exp_ce[i]});
         checkOutput($sformatf("%s_oe_n_c%0d", p, i), {31'd0, bus.sram_oe_n}, {31'd0, exp_oen[i]});
         checkOutput($sformatf("%s_we_n_c%0d", p, i), {31'd0, bus.sram_we_n}, {31'd0, exp_we[i]});
         checkOutput($sformatf("%s_dq_oe_c%0d", p, i), {31'd0, bus.sram_dq_oe}, {31'd0, exp_dqoe[i]});
         checkOutput($sformatf("%s_busy_c%0d", p, i), {31'd0, bus.busy}, {31'd0, exp_busy[i]});
         checkOutput($sformatf("%s_done_c%0d", p, i), {31'd0, bus.done}, {31'd0, exp_done[i]});
         if (i < 4) begin
            checkOutput($sformatf("%s_addr_c%0d", p, i), {21'd0, bus.sram_addr}, {21'd0, addr});
            if (rw) checkOutput($sformatf("%s_dq_out_c%0d", p, i), {24'd0, bus.sram_dq_out}, {24'd0, wdata});
         end
      end
   endtask

   // Monitor: SRAM write capture, scoreboard pop on completion, strobe invariants.
   initial begin
      logic busy_prev = 1'b0;
      logic done_prev = 1'b0;
      sb_item_t it;
      for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[11'h7FF] = 8'hA5;
      forever begin
         @(posedge clk);
         #2;
         if (!bus.sram_ce_n && !bus.sram_we_n) mem[bus.sram_addr] = bus.sram_dq_out;
         if (!reset) begin
            if (bus.busy && !busy_prev) begin
               access_seen++;
               checkOutput("sb_entry_at_start", {31'd0, sb.size() != 0}, 32'd1);
               if (sb.size() != 0) checkOutput("start_addr", {21'd0, bus.sram_addr}, {21'd0, sb[0].addr});
            end
            if (bus.done && !done_prev) begin
               checkOutput("sb_entry_at_done", {31'd0, sb.size() != 0}, 32'd1);
               if (sb.size() != 0) begin
                  it = sb.pop_front();
                  checkOutput("sb_rdata", {24'd0, bus.rdata}, {24'd0, it.rdata_exp});
               end
            end
         end
         checkOutput("oe_we_exclusive", {31'd0, !bus.sram_oe_n && !bus.sram_we_n}, 32'd0);
         checkOutput("dq_oe_during_read", {31'd0, bus.sram_dq_oe && !bus.sram_oe_n}, 32'd0);
         checkOutput("oe_we_exclusive_w0", {31'd0, !bus0.sram_oe_n && !bus0.sram_we_n}, 32'd0);
         busy_prev = bus.busy;
         done_prev = bus.done;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pulses;
      logic prev_busy;

      for (int i = 0; i < 2048; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[11'h7FF] = 8'hA5;
      model_rdata = 8'h00;

      reset = 1'b1;
      bus.cmd_addr = '0;  bus.cmd_wdata = '0;  bus.cmd_rw = 1'b0;  bus.cmd_go = 1'b0;
      bus0.cmd_addr = '0; bus0.cmd_wdata = '0; bus0.cmd_rw = 1'b0; bus0.cmd_go = 1'b0;
      tick(2);

      checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
      checkOutput("rst_overrun", {31'd0, bus.overrun}, 32'd0);
      checkOutput("rst_rdata", {24'd0, bus.rdata}, 32'd0);
      checkOutput("rst_addr", {21'd0, bus.sram_addr}, 32'd0);
      checkOutput("rst_dq_out", {24'd0, bus.sram_dq_out}, 32'd0);
      checkOutput("rst_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
      checkOutput("rst_strobes", {29'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 32'd7);
      reset = 1'b0;
      tick(1);

      // Write 0x3C to 0x2A5
      applyStimulus(11'h2A5, 8'h3C, 1'b1);
      bus.cmd_go = 1'b0;
      runCycles(1'b1, 11'h2A5, 8'h3C);
      tick(1);

      // Read 0x7FF, SRAM returns 0xA5
      applyStimulus(11'h7FF, 8'h00, 1'b0);
      bus.cmd_go = 1'b0;
      runCycles(1'b0, 11'h7FF, 8'h00);
      checkOutput("rd_rdata_7ff", {24'd0, bus.rdata}, 32'hA5);
      tick(1);

      // Overrun: second rising edge during ACCESS with a different address
      applyStimulus(11'h100, 8'h77, 1'b1);
      bus.cmd_go = 1'b0;
      tick(1);
      bus.cmd_addr = 11'h001;
      bus.cmd_rw = 1'b0;
      bus.cmd_go = 1'b1;
      tick(1);
      checkOutput("ovr_flag", {31'd0, bus.overrun}, 32'd1);
      checkOutput("ovr_addr_kept", {21'd0, bus.sram_addr}, 32'h100);
      checkOutput("ovr_rw_kept", {31'd0, bus.sram_we_n}, 32'd0);
      tick(2);
      checkOutput("ovr_done", {31'd0, bus.done}, 32'd1);
      checkOutput("ovr_sticky", {31'd0, bus.overrun}, 32'd1);
      bus.cmd_go = 1'b0;
      tick(1);
      applyStimulus(11'h100, 8'h00, 1'b0);
      bus.cmd_go = 1'b0;
      checkOutput("ovr_cleared", {31'd0, bus.overrun}, 32'd0);
      checkOutput("done_cleared", {31'd0, bus.done}, 32'd0);
      waitDone("ovr_next_done");
      checkOutput("rd_rdata_100", {24'd0, bus.rdata}, 32'h77);
      tick(1);

      // Rising edge coinciding with HOLD->IDLE is an overrun, not an accept
      applyStimulus(11'h2A5, 8'h00, 1'b0);
      bus.cmd_go = 1'b0;
      tick(3);
      checkOutput("hold_busy", {31'd0, bus.busy}, 32'd1);
      bus.cmd_go = 1'b1;
      tick(1);
      checkOutput("hold_ovr_done", {31'd0, bus.done}, 32'd1);
      checkOutput("hold_ovr_flag", {31'd0, bus.overrun}, 32'd1);
      checkOutput("hold_rdata", {24'd0, bus.rdata}, 32'h3C);
      tick(1);
      checkOutput("hold_no_accept", {31'd0, bus.busy}, 32'd0);
      bus.cmd_go = 1'b0;
      tick(1);

      // cmd_go held high for 20 cycles gives one access
      prev_busy = bus.busy;
      pulses = 0;
      applyStimulus(11'h3FF, 8'hE1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         if (i > 0) tick(1);
         if (bus.busy && !prev_busy) pulses++;
         prev_busy = bus.busy;
      end
      checkOutput("held_go_pulses", 32'(pulses), 32'd1);
      checkOutput("held_go_done", {31'd0, bus.done}, 32'd1);
      bus.cmd_go = 1'b0;
      tick(1);

      // Reset in the first ACCESS cycle of a write, with cmd_go still high at release
      applyStimulus(11'h155, 8'h99, 1'b1);
      tick(1);
      checkOutput("abort_we_low", {31'd0, bus.sram_we_n}, 32'd0);
      reset = 1'b1;
      tick(1);
      checkOutput("abort_strobes", {29'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 32'd7);
      checkOutput("abort_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
      checkOutput("abort_done", {31'd0, bus.done}, 32'd0);
      checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
      void'(sb.pop_back());
      model_rdata = 8'h00;
      bus.cmd_addr = 11'h2A5;
      bus.cmd_rw = 1'b0;
      pushExpected(11'h2A5, 8'h00, 1'b0);
      reset = 1'b0;
      tick(1);
      checkOutput("post_rst_accept", {31'd0, bus.busy}, 32'd1);
      checkOutput("post_rst_addr", {21'd0, bus.sram_addr}, 32'h2A5);
      bus.cmd_go = 1'b0;
      waitDone("post_rst_done");
      checkOutput("post_rst_rdata", {24'd0, bus.rdata}, 32'h3C);
      tick(1);

      // WAIT_CYCLES=0 behaves as one strobe cycle, latency 3
      bus0.cmd_addr = 11'h123;
      bus0.cmd_rw = 1'b0;
      bus0.cmd_go = 1'b1;
      tick(1);
      checkOutput("w0_setup_busy", {31'd0, bus0.busy}, 32'd1);
      checkOutput("w0_setup_oe_n", {31'd0, bus0.sram_oe_n}, 32'd1);
      bus0.cmd_go = 1'b0;
      tick(1);
      checkOutput("w0_access_oe_n", {31'd0, bus0.sram_oe_n}, 32'd0);
      checkOutput("w0_access_ce_n", {31'd0, bus0.sram_ce_n}, 32'd0);
      tick(1);
      checkOutput("w0_hold_oe_n", {31'd0, bus0.sram_oe_n}, 32'd1);
      checkOutput("w0_hold_done", {31'd0, bus0.done}, 32'd0);
      tick(1);
      checkOutput("w0_done", {31'd0, bus0.done}, 32'd1);
      checkOutput("w0_busy", {31'd0, bus0.busy}, 32'd0);
      checkOutput("w0_rdata", {24'd0, bus0.rdata}, 32'h6B);

      bus0.cmd_addr = 11'h044;
      bus0.cmd_wdata = 8'hC3;
      bus0.cmd_rw = 1'b1;
      bus0.cmd_go = 1'b1;
      tick(2);
      checkOutput("w0_wr_we_n", {31'd0, bus0.sram_we_n}, 32'd0);
      checkOutput("w0_wr_dq_out", {24'd0, bus0.sram_dq_out}, 32'hC3);
      tick(1);
      checkOutput("w0_wr_hold_we_n", {31'd0, bus0.sram_we_n}, 32'd1);
      checkOutput("w0_wr_hold_dq_oe", {31'd0, bus0.sram_dq_oe}, 32'd1);
      tick(1);
      checkOutput("w0_wr_done", {31'd0, bus0.done}, 32'd1);
      bus0.cmd_go = 1'b0;
      tick(2);

      checkOutput("sb_drained", 32'(sb.size()), 32'd0);
      checkOutput("access_count", 32'(access_seen), 32'(expected_accesses));

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule

// File: doc/sram_access_sequencer.md
SRAM_ACCESS_SEQUENCER -- requirements
Module: sram_access_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, SRAM address width, equal to the width of the address output port.
REQ-002 SHALL have parameter DATA_W, default 8, SRAM data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, number of strobe-active cycles per access; a value of 0 SHALL behave as 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_addr  input  ADDR_W  access address, driven by the address output port.
REQ-007 cmd_wdata  input  DATA_W  write data, driven by the data output port.
REQ-008 cmd_rw  input  1  1 = write, 0 = read; sampled at command accept.
REQ-009 cmd_go  input  1  level from the control output port; each rising edge requests one access.
REQ-010 busy  output  1  high from the cycle after accept until the access completes.
REQ-011 done  output  1  sticky completion flag.
REQ-012 overrun  output  1  sticky flag: a request arrived while busy.
REQ-013 rdata  output  DATA_W  last read result, held until the next read completes.
REQ-014 sram_addr  output  ADDR_W  SRAM address pins.
REQ-015 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes.
REQ-016 sram_dq_out  output  DATA_W  write data to the pad.
REQ-017 sram_dq_oe  output  1  pad output enable.
REQ-018 sram_dq_in  input  DATA_W  read data from the pad.

Function
REQ-019 SHALL register cmd_go into go_q every cycle; go_rise = cmd_go & ~go_q.
REQ-020 SHALL implement an FSM with states IDLE, SETUP, ACCESS and HOLD.
REQ-021 IDLE with go_rise: SHALL latch cmd_addr, cmd_wdata and cmd_rw, clear done and overrun, and go to SETUP.
REQ-022 IDLE without go_rise: SHALL hold all strobes high, sram_dq_oe low and busy low.
REQ-023 SETUP (1 cycle): SHALL drive sram_addr with the latched address and sram_ce_n=0; for a write, sram_dq_oe=1 and sram_dq_out = latched data; SHALL load the wait counter with max(WAIT_CYCLES,1); next state is ACCESS.
REQ-024 ACCESS: SHALL keep CE and address; read drives sram_oe_n=0, write drives sram_we_n=0; the counter SHALL decrement each cycle; on count 1, next state is HOLD.
REQ-025 For a read, the final ACCESS cycle SHALL capture sram_dq_in into rdata.
REQ-026 HOLD (1 cycle): SHALL drive sram_oe_n=1 and sram_we_n=1 while keeping sram_ce_n=0, the address and, for a write, sram_dq_oe=1 and the data (hold time); next state is IDLE with done set to 1.
REQ-027 sram_oe_n and sram_we_n SHALL never be low in the same cycle; sram_dq_oe SHALL never be high during a read.
REQ-028 busy SHALL be 1 exactly in SETUP, ACCESS and HOLD.
REQ-029 Access latency from the go_rise edge to done=1 SHALL be 2+max(WAIT_CYCLES,1) cycles.
REQ-030 go_rise in any state other than IDLE SHALL be ignored for execution and SHALL set overrun; latched command fields SHALL NOT change.
REQ-031 go_rise coinciding with the HOLD to IDLE transition SHALL count as an overrun, not an accept.
REQ-032 cmd_go held high SHALL produce only one access; a new access needs a low-to-high transition.
REQ-033 All strobe, sram_addr, sram_dq_out and sram_dq_oe outputs SHALL be registered, with no combinational path from inputs.

Reset
REQ-034 reset SHALL force the following on the next clk edge: state IDLE, busy=0, done=0, overrun=0, rdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, all strobes=1 and go_q=0.
REQ-035 Reset in the middle of an access SHALL abort it with no done set and strobes inactive the next cycle.
REQ-036 If cmd_go is high when reset releases, it SHALL be seen as a rising edge in the first cycle after reset.

Verification
REQ-037 Write: WAIT_CYCLES=2, addr=0x2A5, wdata=0x3C, rw=1, raise go -> SETUP 1 cycle, sram_we_n low for 2 cycles, dq_oe high for 4 cycles with dq_out=0x3C, done=1 four cycles after the accepting edge.
REQ-038 Read: addr=0x7FF, rw=0, sram_dq_in=0xA5 during ACCESS -> sram_oe_n low for 2 cycles, dq_oe stays 0, rdata=0xA5 and done=1.
REQ-039 Overrun: a second go rising edge during ACCESS with addr=0x001 -> overrun=1, sram_addr unchanged, exactly one access; the next accepted command clears overrun.
REQ-040 Held go: cmd_go high for 20 cycles -> exactly one access and busy pulses once.
REQ-041 Reset mid-write, asserted in the first ACCESS cycle -> next cycle all strobes=1, dq_oe=0 and done=0.
REQ-042 WAIT_CYCLES=0 -> strobe active for 1 cycle and latency of 3 cycles.
